// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode, ALU and PC-source encodings for the multicycle controller
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;
endpackage

// File: rtl/control_output_decode.sv
// control_output_decode: Moore control-signal decode of the FSM state, fetch enables gated by mem_ready
import mips_ctrl_pkg::*;
module control_output_decode (
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);
  // Everything defaults low so IDLE and unused encodings assert nothing
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_JUMP;
      end
      S_ADDI_WB: ctrl.reg_write = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM with retired-instruction counter
import mips_ctrl_pkg::*;
module multicycle_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        illegal_op,
  output logic [31:0] retired,
  output logic [3:0]  state
);
  state_t state_q, state_d;
  ctrl_t  ctrl;
  logic   legal, retire;
  assign legal = opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  assign illegal_op = (state_q == S_DECODE) && !legal;
  assign retire = (state_q inside {S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB}) ||
                  (state_q == S_MEM_WRITE && mem_ready);
  assign state = state_q;
  // Next-state selection; stalls hold in memory states, unused encodings fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:    state_d = (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR :
                             (opcode == OP_RTYPE) ? S_R_EXEC :
                             (opcode == OP_BEQ)   ? S_BRANCH :
                             (opcode == OP_J)     ? S_JUMP :
                             (opcode == OP_ADDI)  ? S_ADDI_EXEC : S_FETCH;
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end
  // State register and retirement counter, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired <= retired + 32'd1;
    end
  end
  control_output_decode u_dec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench for the multicycle controller
module tb_multicycle_control;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        mem_ready = 1'b1;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [31:0] retired;
  logic [3:0]  state;
  int checks = 0;
  int errors = 0;
  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .retired(retired), .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  function automatic logic [12:0] all_ctrl();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, alu_src_b != 0, alu_op != 0};
  endfunction
  initial begin
    #12;
    chk("rst_state", 32'(state), 0);
    chk("rst_retired", retired, 0);
    chk("rst_outs", 32'(all_ctrl()), 0);
    chk("rst_pcsrc", 32'(pc_source), 0);
    step();
    rst_n = 1'b1;
    opcode = 6'b000000;
    step();
    chk("r_fetch_state", 32'(state), 1);
    chk("r_fetch_ctl", {pc_write, ir_write, mem_read, i_or_d, alu_src_a, alu_src_b, alu_op}, 32'b1110_0_01_00);
    step();
    chk("r_decode_state", 32'(state), 2);
    chk("r_decode_srcb", 32'(alu_src_b), 3);
    step();
    chk("r_exec_state", 32'(state), 7);
    chk("r_exec_ctl", {alu_src_a, alu_src_b, alu_op}, 32'b1_00_10);
    step();
    chk("r_wb_state", 32'(state), 8);
    chk("r_wb_ctl", {reg_write, reg_dst, mem_to_reg}, 32'b110);
    step();
    chk("r_done_state", 32'(state), 1);
    chk("r_retired", retired, 1);
    mem_ready = 1'b0;
    #1;
    chk("fetch_stall_en", {ir_write, pc_write, mem_read}, 32'b001);
    step();
    chk("fetch_stall_state", 32'(state), 1);
    mem_ready = 1'b1;
    opcode = 6'b111111;
    step();
    chk("ill_decode_state", 32'(state), 2);
    chk("ill_pulse", 32'(illegal_op), 1);
    step();
    chk("ill_next_state", 32'(state), 1);
    chk("ill_pulse_off", 32'(illegal_op), 0);
    chk("ill_retired", retired, 1);
    opcode = 6'b100011;
    step();
    step();
    chk("lw_addr_state", 32'(state), 3);
    chk("lw_addr_ctl", {alu_src_a, alu_src_b, alu_op}, 32'b1_10_00);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lw_stall_state", 32'(state), 4);
      chk("lw_stall_ctl", {mem_read, i_or_d, reg_write, mem_write}, 32'b1100);
    end
    mem_ready = 1'b1;
    #1;
    chk("lw_read_last", {state, mem_read}, {4'd4, 1'b1});
    step();
    chk("lw_wb_state", 32'(state), 5);
    chk("lw_wb_ctl", {reg_write, mem_to_reg, reg_dst}, 32'b110);
    step();
    chk("lw_retired", retired, 2);
    opcode = 6'b000100;
    step();
    chk("beq_decode_cond", {pc_write_cond, pc_source}, 0);
    step();
    chk("beq_state", 32'(state), 9);
    chk("beq_ctl", {pc_write_cond, pc_source, alu_op, alu_src_a}, 32'b1_01_01_1);
    step();
    chk("beq_back_fetch", 32'(state), 1);
    chk("beq_fetch_cond", 32'(pc_write_cond), 0);
    chk("beq_retired", retired, 3);
    opcode = 6'b001000;
    step();
    step();
    chk("addi_exec", {state, alu_src_a, alu_src_b}, {4'd11, 1'b1, 2'b10});
    step();
    chk("addi_wb", {state, reg_write, reg_dst, mem_to_reg}, {4'd12, 3'b100});
    step();
    chk("addi_retired", retired, 4);
    opcode = 6'b000010;
    step();
    force dut.retired = 32'hFFFF_FFFF;
    step();
    release dut.retired;
    chk("j_state", 32'(state), 10);
    chk("j_ctl", {pc_write, pc_source}, 32'b1_10);
    step();
    chk("j_wrap", retired, 0);
    opcode = 6'b101011;
    step();
    step();
    chk("sw_addr_state", 32'(state), 3);
    mem_ready = 1'b0;
    step();
    chk("sw_state", 32'(state), 6);
    chk("sw_ctl", {mem_write, mem_read, i_or_d}, 32'b101);
    step();
    chk("sw_stall_state", 32'(state), 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 0);
    chk("async_rst_memw", 32'(mem_write), 0);
    chk("async_rst_retired", retired, 0);
    chk("async_rst_outs", 32'(all_ctrl()), 0);
    step();
    chk("rst_hold_state", 32'(state), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
